cordic_vector: RTL

- Iterative vectoring-mode CORDIC. It takes a Cartesian vector (x, y) and returns its magnitude and its angle, atan2(y, x).
- It is the inverse of the pipelined rotation-mode CORDIC: that block turns an angle into a rotated vector, and this block recovers the angle and length from a vector.
- Used after the rotator and demod paths to extract phase and amplitude.
- Processes one transaction at a time, one micro-rotation per clock, with valid/ready handshakes on both input and output.

---
 rtl/cordic_vector.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: returns |(x, y)| and atan2(y, x), one micro-rotation per clock.
// Define CORDIC_VECTOR_GAIN_COMP_EN to add the SCALE state that removes the CORDIC gain from mag_out.
module cordic_vector #(
  parameter int ITER = 16,
  parameter int XY_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XY_W-1:0] xin,
  input  logic [XY_W-1:0] yin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XY_W-1:0] mag_out,
  output logic [31:0]     angle_out,
  output logic            busy
);
  localparam int W = XY_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_PREROT, S_ITER, S_SCALE, S_DONE} state_t;

  state_t              state;
  logic signed [W-1:0] x, y;
  logic [31:0]         z;
  logic [3:0]          iter_cnt;
  logic                zero;

  logic signed [W-1:0] x_shr, y_shr, x_next, y_next;
  logic [31:0]         z_next;
  logic                last_iter;

  // atan(2^-i) with 2^32 = one full turn
  function automatic logic [31:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 32'h2000_0000;
      4'd1:    return 32'h12E4_051E;
      4'd2:    return 32'h09FB_385B;
      4'd3:    return 32'h0511_11D4;
      4'd4:    return 32'h028B_0D43;
      4'd5:    return 32'h0145_D7E1;
      4'd6:    return 32'h00A2_F61E;
      4'd7:    return 32'h0051_7C55;
      4'd8:    return 32'h0028_BE53;
      4'd9:    return 32'h0014_5F2F;
      4'd10:   return 32'h000A_2F98;
      4'd11:   return 32'h0005_17CC;
      4'd12:   return 32'h0002_8BE6;
      4'd13:   return 32'h0001_45F3;
      4'd14:   return 32'h0000_A2FA;
      default: return 32'h0000_517D;
    endcase
  endfunction

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    x_shr = x >>> iter_cnt;
    y_shr = y >>> iter_cnt;
    if (!y[W-1]) begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + atan_lut(iter_cnt);
    end else begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - atan_lut(iter_cnt);
    end
  end

  assign last_iter = (iter_cnt == 4'(ITER - 1));
  assign busy      = (state != S_IDLE);

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  // 1/K ~= 9949 / 2^14; summing before the single shift keeps one truncation only
  localparam int PW = W + 15;
  logic signed [PW-1:0] x_wide, x_scaled;

  always_comb begin
    x_wide   = PW'(x);
    x_scaled = (x_wide <<< 13) + (x_wide <<< 10) + (x_wide <<< 9) + (x_wide <<< 7)
             + (x_wide <<< 6)  + (x_wide <<< 4)  + (x_wide <<< 3) + (x_wide <<< 2)
             + x_wide;
  end
`else
  function automatic logic [XY_W-1:0] sat_mag(input logic signed [W-1:0] v);
    if (v[W-1])             return '0;
    else if (|v[W-2:XY_W])  return '1;
    return v[XY_W-1:0];
  endfunction
`endif

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge x, y and z.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mag_out   <= '0;
      angle_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            x        <= {{2{xin[XY_W-1]}}, xin};
            y        <= {{2{yin[XY_W-1]}}, yin};
            zero     <= (xin == '0) && (yin == '0);
            in_ready <= 1'b0;
            state    <= S_PREROT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_PREROT: begin
          // Fold the left half-plane into the right with a +-90 degree turn
          if (!x[W-1]) begin
            z <= 32'h0000_0000;
          end else if (!y[W-1]) begin
            x <= y;
            y <= -x;
            z <= 32'h4000_0000;
          end else begin
            x <= -y;
            y <= x;
            z <= 32'hC000_0000;
          end
          iter_cnt <= '0;
          state    <= S_ITER;
        end
        S_ITER: begin
          x        <= x_next;
          y        <= y_next;
          z        <= z_next;
          iter_cnt <= iter_cnt + 4'd1;
          if (last_iter) begin
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            state <= S_SCALE;
`else
            mag_out   <= zero ? '0 : sat_mag(x_next);
            angle_out <= zero ? '0 : z_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
`endif
          end
        end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
        S_SCALE: begin
          mag_out   <= zero ? '0 : XY_W'(x_scaled >>> 14);
          angle_out <= zero ? '0 : z;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // NOTE: x, y, z, iter_cnt and zero are deliberately left out of reset; state qualifies them.

endmodule
